// File: rtl/vsc_pkg.sv
// Shared definitions for vector_sweep_checker: FSM state encoding, latency limit
// and the saturating adder used by the error counter.
package vsc_pkg;

  typedef logic [1:0] vsc_state_t;

  localparam vsc_state_t ST_IDLE  = 2'd0;
  localparam vsc_state_t ST_SWEEP = 2'd1;
  localparam vsc_state_t ST_DRAIN = 2'd2;
  localparam vsc_state_t ST_DONE  = 2'd3;

  localparam int MAX_LAT = 7;

  // Add two unsigned values and clamp the result at max_v.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_v}) return max_v;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/vsc_delay_line.sv
// LAT-stage shift register carrying {valid, index} alongside the DUT pipeline.
// LAT=0 is a wire-through; flush clears every stage synchronously.
module vsc_delay_line #(
  parameter int IDX_W = 4,
  parameter int LAT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             pending
);

  if (LAT == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, reset, flush};
    assign out_valid  = in_valid;
    assign out_idx    = in_idx;
    assign pending    = 1'b0;
  end else begin : g_pipe
    logic [LAT-1:0]   valid_q;
    logic [IDX_W-1:0] idx_q [LAT];

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        valid_q <= '0;
        for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
      end else begin
        valid_q[0] <= in_valid;
        idx_q[0]   <= in_idx;
        for (int i = 1; i < LAT; i++) begin
          valid_q[i] <= valid_q[i-1];
          idx_q[i]   <= idx_q[i-1];
        end
      end
    end

    // The last stage is compared this cycle, so only earlier stages are still pending.
    always_comb begin
      pending = 1'b0;
      for (int i = 0; i < LAT - 1; i++) pending = pending | valid_q[i];
    end

    assign out_valid = valid_q[LAT-1];
    assign out_idx   = idx_q[LAT-1];
  end

endmodule

// File: rtl/vector_sweep_checker.sv
// Exhaustive-sweep checker: drives codes 0..2**IN_W-1, compares N_CH DUT outputs
// against a golden output after LAT cycles. Optional printing via VSC_LOG_EN.
module vector_sweep_checker
  import vsc_pkg::*;
#(
  parameter int IN_W         = 4,
  parameter int OUT_W        = 7,
  parameter int N_CH         = 2,
  parameter int LAT          = 0,
  parameter int STOP_ON_FAIL = 1,
  parameter int CNT_W        = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic [IN_W-1:0]                       stim,
  output logic                                  stim_valid,
  input  logic [N_CH*OUT_W-1:0]                 dut_out,
  input  logic [OUT_W-1:0]                      ref_out,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  pass,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] fail_ch,
  output logic [IN_W-1:0]                       fail_vec,
  output logic [OUT_W-1:0]                      fail_exp,
  output logic [OUT_W-1:0]                      fail_got,
  output logic [CNT_W-1:0]                      err_count
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int NM_W = $clog2(N_CH + 1);
  localparam logic [IN_W-1:0] LAST_CODE = '1;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  vsc_state_t       state_q, state_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic             seen_q, seen_d;
  logic [CH_W-1:0]  fail_ch_q, fail_ch_d;
  logic [IN_W-1:0]  fail_vec_q, fail_vec_d;
  logic [OUT_W-1:0] fail_exp_q, fail_exp_d;
  logic [OUT_W-1:0] fail_got_q, fail_got_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             d_valid, pending, flush, any_mism;
  logic [IN_W-1:0]  d_idx;
  logic [N_CH-1:0]  mism;
  logic [NM_W-1:0]  n_mism;
  logic [CH_W-1:0]  first_ch;
  logic [OUT_W-1:0] first_got;

  assign stim_valid = (state_q == ST_SWEEP);
  assign busy       = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_cnt_q == '0);
  assign stim       = stim_q;
  assign fail_ch    = fail_ch_q;
  assign fail_vec   = fail_vec_q;
  assign fail_exp   = fail_exp_q;
  assign fail_got   = fail_got_q;
  assign err_count  = err_cnt_q;

  assign flush = (STOP_ON_FAIL != 0) && any_mism;

  vsc_delay_line #(.IDX_W(IN_W), .LAT(LAT)) u_dly (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (stim_valid),
    .in_idx   (stim_q),
    .out_valid(d_valid),
    .out_idx  (d_idx),
    .pending  (pending)
  );

  // Walk channels high to low so the lowest mismatching channel is the one kept.
  always_comb begin
    mism      = '0;
    n_mism    = '0;
    first_ch  = '0;
    first_got = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      mism[c] = d_valid && busy && (dut_out[c*OUT_W +: OUT_W] != ref_out);
      if (mism[c]) begin
        first_ch  = CH_W'(c);
        first_got = dut_out[c*OUT_W +: OUT_W];
      end
      n_mism = n_mism + NM_W'(mism[c]);
    end
  end

  assign any_mism = |mism;

  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    seen_d     = seen_q;
    fail_ch_d  = fail_ch_q;
    fail_vec_d = fail_vec_q;
    fail_exp_d = fail_exp_q;
    fail_got_d = fail_got_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_SWEEP;
          stim_d     = '0;
          seen_d     = 1'b0;
          fail_ch_d  = '0;
          fail_vec_d = '0;
          fail_exp_d = '0;
          fail_got_d = '0;
          err_cnt_d  = '0;
        end
      end
      ST_SWEEP: begin
        if (stim_q == LAST_CODE) state_d = ST_DRAIN;
        else                     stim_d  = stim_q + IN_W'(1);
      end
      ST_DRAIN: begin
        if (!pending) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (any_mism) begin
      err_cnt_d = CNT_W'(sat_add(32'(err_cnt_q), 32'(n_mism), CNT_MAX));
      if (!seen_q) begin
        seen_d     = 1'b1;
        fail_ch_d  = first_ch;
        fail_vec_d = d_idx;
        fail_exp_d = ref_out;
        fail_got_d = first_got;
      end
      if (STOP_ON_FAIL != 0) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      stim_q     <= '0;
      seen_q     <= 1'b0;
      fail_ch_q  <= '0;
      fail_vec_q <= '0;
      fail_exp_q <= '0;
      fail_got_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      seen_q     <= seen_d;
      fail_ch_q  <= fail_ch_d;
      fail_vec_q <= fail_vec_d;
      fail_exp_q <= fail_exp_d;
      fail_got_q <= fail_got_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

`ifdef VSC_LOG_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (any_mism && !seen_q)
        $display("[%0t ns]: ch %0d (input 0x%0h) expected 0x%0h, got 0x%0h",
                 $time, first_ch, d_idx, ref_out, first_got);
      if (state_q != ST_DONE && state_d == ST_DONE) begin
        if (err_cnt_d == '0) $display("PASS");
        else                 $display("FAIL %0d errors", err_cnt_d);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Directed bench for vector_sweep_checker: four instances cover LAT=0 stop/continue,
// LAT=3 registered paths and a 2-bit saturating counter; seven-seg decoders as DUTs.
`timescale 1ns/1ps
module tb_vector_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, start_b, start_c, start_d;
  logic a_fault, c_late;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Instance A: LAT=0, stop on first fail
  logic [3:0] stim_a, fvec_a; logic sv_a, busy_a, done_a, pass_a, fch_a;
  logic [13:0] dut_a; logic [6:0] ref_a, fexp_a, fgot_a; logic [15:0] err_a;
  assign dut_a = {(a_fault && stim_a == 4'h9) ? 7'h10 : seg(stim_a), seg(stim_a)};
  assign ref_a = seg(stim_a);
  vector_sweep_checker #(.IN_W(4), .OUT_W(7), .N_CH(2), .LAT(0), .STOP_ON_FAIL(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .stim(stim_a), .stim_valid(sv_a),
    .dut_out(dut_a), .ref_out(ref_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_ch(fch_a), .fail_vec(fvec_a), .fail_exp(fexp_a), .fail_got(fgot_a), .err_count(err_a));

  // Instance B: LAT=0, count every mismatch
  logic [3:0] stim_b, fvec_b; logic sv_b, busy_b, done_b, pass_b, fch_b;
  logic [13:0] dut_b; logic [6:0] ref_b, fexp_b, fgot_b; logic [15:0] err_b;
  assign dut_b = {(stim_b == 4'h3) ? 7'h01 : seg(stim_b),
                  (stim_b == 4'h3) ? 7'h00 : (stim_b == 4'hA) ? 7'h55 : seg(stim_b)};
  assign ref_b = seg(stim_b);
  vector_sweep_checker #(.IN_W(4), .OUT_W(7), .N_CH(2), .LAT(0), .STOP_ON_FAIL(0), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .stim(stim_b), .stim_valid(sv_b),
    .dut_out(dut_b), .ref_out(ref_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_ch(fch_b), .fail_vec(fvec_b), .fail_exp(fexp_b), .fail_got(fgot_b), .err_count(err_b));

  // Instance C: LAT=3, registered DUT and golden; golden optionally one cycle late
  logic [3:0] stim_c, fvec_c; logic sv_c, busy_c, done_c, pass_c, fch_c;
  logic [13:0] dut_c; logic [6:0] ref_c, fexp_c, fgot_c; logic [15:0] err_c;
  logic [6:0] pipe_c [4];
  always @(posedge clk) begin
    pipe_c[0] <= seg(stim_c);
    pipe_c[1] <= pipe_c[0];
    pipe_c[2] <= pipe_c[1];
    pipe_c[3] <= pipe_c[2];
  end
  assign dut_c = {pipe_c[2], pipe_c[2]};
  assign ref_c = c_late ? pipe_c[3] : pipe_c[2];
  vector_sweep_checker #(.IN_W(4), .OUT_W(7), .N_CH(2), .LAT(3), .STOP_ON_FAIL(1), .CNT_W(16)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .stim(stim_c), .stim_valid(sv_c),
    .dut_out(dut_c), .ref_out(ref_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .fail_ch(fch_c), .fail_vec(fvec_c), .fail_exp(fexp_c), .fail_got(fgot_c), .err_count(err_c));

  // Instance D: 2-bit counter, channel 0 always wrong
  logic [3:0] stim_d, fvec_d; logic sv_d, busy_d, done_d, pass_d, fch_d;
  logic [13:0] dut_d; logic [6:0] ref_d, fexp_d, fgot_d; logic [1:0] err_d;
  assign dut_d = {seg(stim_d), seg(stim_d) ^ 7'h01};
  assign ref_d = seg(stim_d);
  vector_sweep_checker #(.IN_W(4), .OUT_W(7), .N_CH(2), .LAT(0), .STOP_ON_FAIL(0), .CNT_W(2)) u_d (
    .clk(clk), .reset(reset), .start(start_d), .stim(stim_d), .stim_valid(sv_d),
    .dut_out(dut_d), .ref_out(ref_d), .busy(busy_d), .done(done_d), .pass(pass_d),
    .fail_ch(fch_d), .fail_vec(fvec_d), .fail_exp(fexp_d), .fail_got(fgot_d), .err_count(err_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    a_fault = 1'b0; c_late = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_stim", 32'(stim_a), 32'd0);
    check("rst_valid", 32'(sv_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);

    // clean sweep, LAT=0: 16 SWEEP cycles + 1 DRAIN
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("a_stim_%0d", i), 32'(stim_a), 32'(i));
      check($sformatf("a_valid_%0d", i), 32'(sv_a), 32'd1);
      tick();
    end
    check("a_drain_valid", 32'(sv_a), 32'd0);
    check("a_drain_busy", 32'(busy_a), 32'd1);
    check("a_drain_done", 32'(done_a), 32'd0);
    tick();
    check("a_done", 32'(done_a), 32'd1);
    check("a_busy_low", 32'(busy_a), 32'd0);
    check("a_pass", 32'(pass_a), 32'd1);
    check("a_err0", 32'(err_a), 32'd0);

    // channel 1 wrong at 0x9, stop on fail
    a_fault = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (9) tick();
    check("a2_stim9", 32'(stim_a), 32'h9);
    check("a2_valid9", 32'(sv_a), 32'd1);
    tick();
    check("a2_valid_drop", 32'(sv_a), 32'd0);
    check("a2_done", 32'(done_a), 32'd1);
    check("a2_pass", 32'(pass_a), 32'd0);
    check("a2_fail_ch", 32'(fch_a), 32'd1);
    check("a2_fail_vec", 32'(fvec_a), 32'h9);
    check("a2_fail_exp", 32'(fexp_a), 32'h6F);
    check("a2_fail_got", 32'(fgot_a), 32'h10);
    check("a2_err", 32'(err_a), 32'd1);

    // restart clears results; start during SWEEP ignored; reset mid-sweep
    a_fault = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("a3_done_clr", 32'(done_a), 32'd0);
    check("a3_err_clr", 32'(err_a), 32'd0);
    check("a3_fvec_clr", 32'(fvec_a), 32'd0);
    repeat (3) tick();
    check("a3_stim3", 32'(stim_a), 32'h3);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("a3_start_ignored", 32'(stim_a), 32'h4);
    check("a3_busy", 32'(busy_a), 32'd1);
    repeat (3) tick();
    check("a3_stim7", 32'(stim_a), 32'h7);
    reset = 1'b1; tick(); reset = 1'b0;
    check("a3_rst_busy", 32'(busy_a), 32'd0);
    check("a3_rst_valid", 32'(sv_a), 32'd0);
    check("a3_rst_stim", 32'(stim_a), 32'd0);
    check("a3_rst_done", 32'(done_a), 32'd0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("a3_restart_stim", 32'(stim_a), 32'd0);
    check("a3_restart_valid", 32'(sv_a), 32'd1);
    repeat (17) tick();
    check("a3_done", 32'(done_a), 32'd1);
    check("a3_pass", 32'(pass_a), 32'd1);

    // continue on fail: both channels at 0x3, channel 0 at 0xA
    start_b = 1'b1; tick(); start_b = 1'b0;
    repeat (16) tick();
    check("b_drain_busy", 32'(busy_b), 32'd1);
    tick();
    check("b_done", 32'(done_b), 32'd1);
    check("b_pass", 32'(pass_b), 32'd0);
    check("b_err", 32'(err_b), 32'd3);
    check("b_fail_ch", 32'(fch_b), 32'd0);
    check("b_fail_vec", 32'(fvec_b), 32'h3);
    check("b_fail_exp", 32'(fexp_b), 32'h4F);
    check("b_fail_got", 32'(fgot_b), 32'h00);

    // LAT=3: done exactly 19 cycles after SWEEP entry
    start_c = 1'b1; tick(); start_c = 1'b0;
    repeat (18) tick();
    check("c_busy18", 32'(busy_c), 32'd1);
    check("c_done18", 32'(done_c), 32'd0);
    tick();
    check("c_done19", 32'(done_c), 32'd1);
    check("c_pass", 32'(pass_c), 32'd1);

    // golden one cycle late: first delayed compare (vector 0) sees seg(0xF)
    c_late = 1'b1;
    start_c = 1'b1; tick(); start_c = 1'b0;
    check("c2_stim0", 32'(stim_c), 32'd0);
    repeat (3) tick();
    check("c2_busy3", 32'(busy_c), 32'd1);
    tick();
    check("c2_done", 32'(done_c), 32'd1);
    check("c2_valid", 32'(sv_c), 32'd0);
    check("c2_pass", 32'(pass_c), 32'd0);
    check("c2_fail_vec", 32'(fvec_c), 32'd0);
    check("c2_fail_ch", 32'(fch_c), 32'd0);
    check("c2_fail_exp", 32'(fexp_c), 32'h71);
    check("c2_fail_got", 32'(fgot_c), 32'h3F);
    check("c2_err", 32'(err_c), 32'd2);

    // saturating 2-bit counter
    start_d = 1'b1; tick(); start_d = 1'b0;
    repeat (17) tick();
    check("d_done", 32'(done_d), 32'd1);
    check("d_err_sat", 32'(err_d), 32'd3);
    check("d_pass", 32'(pass_d), 32'd0);
    check("d_fail_vec", 32'(fvec_d), 32'd0);
    check("d_fail_got", 32'(fgot_d), 32'h3E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
